// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short/double/long press strobes and a held level.
// Optional auto-repeat while held is built only when BUTTON_REPEAT_EN is defined.
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clean_in,
  output logic short_press_out,
  output logic double_press_out,
  output logic long_press_out,
  output logic repeat_out,
  output logic held_out
);

  localparam int MAX_LG  = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int MAX_CYC = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HELD,
    WAIT_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic             rise;

`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic             repeat_q, repeat_d;
`endif

  assign rise = clean_in & ~prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    prev_d   = clean_in;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef BUTTON_REPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (!clean_in) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end
      end
      WAIT_GAP: begin
        // A rise on the expiry cycle still counts as the second press.
        if (rise) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      PRESS2: begin
        if (!clean_in) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == LONG_LAST) begin
          double_d = 1'b1;
          state_d  = WAIT_RELEASE;
          cnt_d    = '0;
        end
      end
      LONG_HELD: begin
        if (!clean_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
`ifdef BUTTON_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      WAIT_RELEASE: begin
        cnt_d = '0;
        if (!clean_in) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == LONG_HELD);
  end

  // prev resets high so a button held through reset must be released first.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= held_d;
    end
  end

`ifdef BUTTON_REPEAT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) repeat_q <= 1'b0;
    else         repeat_q <= repeat_d;
  end
  assign repeat_out = repeat_q;
`else
  assign repeat_out = 1'b0;
`endif

  assign short_press_out  = short_q;
  assign double_press_out = double_q;
  assign long_press_out   = long_q;
  assign held_out         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random press/release traffic
// checked every cycle against a timestamp-based reference model.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int REP  = 3;

  localparam int M_IDLE = 0, M_FIRST = 1, M_GAP = 2, M_SECOND = 3, M_LONG = 4, M_WAITREL = 5;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic clean_in = 1'b0;
  logic short_press_out, double_press_out, long_press_out, repeat_out, held_out;

  button_event_decoder #(
    .LONG_PRESS_CYCLES(LONG),
    .DOUBLE_GAP_CYCLES(GAP),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clean_in(clean_in),
    .short_press_out(short_press_out),
    .double_press_out(double_press_out),
    .long_press_out(long_press_out),
    .repeat_out(repeat_out),
    .held_out(held_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int gc = 0;
  int lc = 0;

  int   m_mode = M_IDLE;
  int   m_mark = 0;
  logic m_prev = 1'b1;
  logic m_short, m_double, m_long, m_repeat, m_held;

  int s_cnt[5];
  int s_first[5];
  int s_last[5];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b edge=%0d", tag, obs, exp, gc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: events follow from the elapsed time since the current phase began.
  task automatic model_update(input logic c, input logic r);
    logic rise;
    int   el;
    m_short = 0; m_double = 0; m_long = 0; m_repeat = 0;
    if (!r) begin
      m_mode = M_IDLE;
      m_prev = 1'b1;
      m_held = 1'b0;
      return;
    end
    rise = c && !m_prev;
    el   = gc - m_mark;
    case (m_mode)
      M_IDLE:   if (rise) begin m_mode = M_FIRST; m_mark = gc; end
      M_FIRST:  if (!c) begin m_mode = M_GAP; m_mark = gc; end
                else if (el == LONG) begin m_long = 1; m_mode = M_LONG; m_mark = gc; end
      M_GAP:    if (rise) begin m_mode = M_SECOND; m_mark = gc; end
                else if (el == GAP) begin m_short = 1; m_mode = M_IDLE; end
      M_SECOND: if (!c) begin m_double = 1; m_mode = M_IDLE; end
                else if (el == LONG) begin m_double = 1; m_mode = M_WAITREL; end
      M_LONG:   if (!c) m_mode = M_IDLE;
                else begin
`ifdef BUTTON_REPEAT_EN
                  if (el % REP == 0) m_repeat = 1;
`endif
                end
      default:  if (!c) m_mode = M_IDLE;
    endcase
    m_held = (m_mode == M_LONG);
    m_prev = c;
  endtask

  task automatic note(input int i);
    if (s_cnt[i] == 0) s_first[i] = lc + 1;
    s_last[i] = lc + 1;
    s_cnt[i]++;
  endtask

  task automatic begin_scn();
    lc = 0;
    for (int i = 0; i < 5; i++) begin
      s_cnt[i] = 0; s_first[i] = -1; s_last[i] = -1;
    end
  endtask

  task automatic step(input logic c, input logic r);
    int strobes;
    clean_in = c;
    rst_in   = r;
    @(posedge clk_in);
    #1;
    gc++;
    lc++;
    model_update(c, r);
    chk("short", short_press_out, m_short);
    chk("double", double_press_out, m_double);
    chk("long", long_press_out, m_long);
    chk("repeat", repeat_out, m_repeat);
    chk("held", held_out, m_held);
    strobes = int'(short_press_out) + int'(double_press_out) + int'(long_press_out) + int'(repeat_out);
    chk_int("single_strobe", (strobes > 1) ? 1 : 0, 0);
    if (short_press_out)  note(0);
    if (double_press_out) note(1);
    if (long_press_out)   note(2);
    if (repeat_out)       note(3);
    if (held_out)         note(4);
  endtask

  task automatic run(input logic c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_short", short_press_out, 1'b0);
    chk("rst_held", held_out, 1'b0);

    // single short press
    begin_scn();
    run(0, 9); run(1, 3); run(0, 15);
    chk_int("short_cnt", s_cnt[0], 1);
    chk_int("short_at", s_first[0], 18);
    chk_int("short_other", s_cnt[1] + s_cnt[2] + s_cnt[3] + s_cnt[4], 0);

    // long press held 20 cycles
    do_reset();
    begin_scn();
    run(0, 9); run(1, 20); run(0, 10);
    chk_int("long_cnt", s_cnt[2], 1);
    chk_int("long_at", s_first[2], 19);
    chk_int("held_first", s_first[4], 19);
    chk_int("held_last", s_last[4], 30);
    chk_int("long_no_short", s_cnt[0], 0);
`ifdef BUTTON_REPEAT_EN
    chk_int("rep_cnt", s_cnt[3], 3);
    chk_int("rep_first", s_first[3], 22);
    chk_int("rep_last", s_last[3], 28);
`else
    chk_int("rep_cnt", s_cnt[3], 0);
`endif

    // double press
    do_reset();
    begin_scn();
    run(0, 9); run(1, 3); run(0, 2); run(1, 3); run(0, 12);
    chk_int("dbl_cnt", s_cnt[1], 1);
    chk_int("dbl_at", s_first[1], 19);
    chk_int("dbl_no_short", s_cnt[0], 0);

    // double press with second press held long, then a normal short press
    do_reset();
    begin_scn();
    run(0, 9); run(1, 3); run(0, 2); run(1, 16); run(0, 10);
    chk_int("dbll_cnt", s_cnt[1], 1);
    chk_int("dbll_at", s_first[1], 24);
    chk_int("dbll_no_long", s_cnt[2] + s_cnt[3] + s_cnt[4], 0);
    run(1, 2); run(0, 10);
    chk_int("dbll_then_short", s_cnt[0], 1);
    chk_int("dbll_short_at", s_first[0], 48);

    // reset while held
    begin_scn();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    run(1, 10);
    chk_int("held_rst_quiet", s_cnt[0] + s_cnt[1] + s_cnt[2] + s_cnt[3] + s_cnt[4], 0);
    run(0, 5); run(1, 3); run(0, 10);
    chk_int("held_rst_short", s_cnt[0], 1);

    // reset in the gap
    do_reset();
    begin_scn();
    run(0, 3); run(1, 3); run(0, 2);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    run(0, 10);
    chk_int("gap_rst_quiet", s_cnt[0] + s_cnt[1] + s_cnt[2] + s_cnt[3] + s_cnt[4], 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        int nr;
        nr = $urandom_range(1, 2);
        for (int k = 0; k < nr; k++) step(1'($urandom_range(0, 1)), 1'b0);
      end
      run(1, $urandom_range(1, 13));
      run(0, $urandom_range(1, 7));
    end
    run(0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
